rotor_unit: RTL and testbench

ROTOR_UNIT -- requirements
Module: rotor_unit

---
 rtl/enigma_pkg.sv | 27 ++
 rtl/rotor_modmap.sv | 23 ++
 rtl/rotor_unit.sv | 75 +++++++
 tb/tb_rotor_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// enigma_pkg: alphabet constants, mod-N helpers and the standard rotor wirings I-V with notches
package enigma_pkg;
  localparam int N = 26;
  localparam int W = 5;
  typedef logic [W:0] wide_t;
  localparam logic [8*26-1:0] ROTOR_I   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  localparam logic [8*26-1:0] ROTOR_II  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
  localparam logic [8*26-1:0] ROTOR_III = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
  localparam logic [8*26-1:0] ROTOR_IV  = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
  localparam logic [8*26-1:0] ROTOR_V   = "VZBRGITYUPSDNHLWMKCQXOAEFJ";
  localparam int NOTCH_I   = 16;
  localparam int NOTCH_II  = 4;
  localparam int NOTCH_III = 21;
  localparam int NOTCH_IV  = 9;
  localparam int NOTCH_V   = 25;
  function automatic wide_t mod_add(input wide_t a, input wide_t b, input wide_t n);
    wide_t s;
    s = a + b;
    return s >= n ? s - n : s;
  endfunction
  function automatic wide_t mod_sub(input wide_t a, input wide_t b, input wide_t n);
    return a >= b ? a - b : a + n - b;
  endfunction
  function automatic logic [W-1:0] rotor_sym(input logic [8*26-1:0] w, input int i);
    return W'(w[8*(25-i) +: 8] - 8'd65);
  endfunction
endpackage

// File: rtl/rotor_modmap.sv
// rotor_modmap: combinational offset, table lookup and unoffset of one symbol
module rotor_modmap #(
  parameter int N = enigma_pkg::N,
  parameter int W = enigma_pkg::W
) (
  input  logic [N-1:0][W-1:0] tbl,
  input  logic [W-1:0]        pos,
  input  logic [W-1:0]        ring,
  input  logic [W-1:0]        sym,
  output logic [W-1:0]        res
);
  import enigma_pkg::*;
  wide_t e, idx, sub;
  logic [W-1:0] hit;
  always_comb begin
    e = mod_sub(wide_t'(pos), wide_t'(ring), wide_t'(N));
    idx = mod_add(wide_t'(sym), e, wide_t'(N));
    hit = '0;
    for (int k = 0; k < N; k++) hit = (idx == wide_t'(k)) ? tbl[k] : hit;
    sub = mod_sub(wide_t'(hit), e, wide_t'(N));
  end
  assign res = W'(sub);
endmodule

// File: rtl/rotor_unit.sv
// rotor_unit: stepping substitution rotor with programmable wiring and valid/ready streaming
module rotor_unit #(
  parameter int N     = enigma_pkg::N,
  parameter int W     = enigma_pkg::W,
  parameter int NOTCH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_addr,
  input  logic [W-1:0] cfg_data,
  input  logic         pos_load,
  input  logic [W-1:0] pos_val,
  input  logic [W-1:0] ring_val,
  input  logic         step_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_dir,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_err,
  output logic         carry_out,
  output logic [W-1:0] pos_out
);
  import enigma_pkg::*;
  logic [N-1:0][W-1:0] fwd, rev;
  logic [W-1:0] pos, ring, mapped;
  logic acc, err, cfg_ok;
  assign in_ready = (!out_valid | out_ready) & !cfg_we & !pos_load;
  assign acc = in_valid & in_ready;
  assign err = wide_t'(in_data) >= wide_t'(N);
  assign cfg_ok = (wide_t'(cfg_addr) < wide_t'(N)) && (wide_t'(cfg_data) < wide_t'(N));
  assign pos_out = pos;
  rotor_modmap #(.N(N), .W(W)) u_map (
    .tbl  (in_dir ? rev : fwd),
    .pos  (pos),
    .ring (ring),
    .sym  (in_data),
    .res  (mapped)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        fwd[k] <= W'(k);
        rev[k] <= W'(k);
      end
    end else if (cfg_we && cfg_ok) begin
      fwd[cfg_addr] <= cfg_data;
      rev[cfg_data] <= cfg_addr;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pos <= '0;
      ring <= '0;
      carry_out <= 1'b0;
    end else begin
      carry_out <= step_in & !pos_load & (pos == W'(NOTCH));
      if (pos_load) begin
        pos <= W'(32'(pos_val) % N);
        ring <= W'(32'(ring_val) % N);
      end else if (step_in) pos <= (pos == W'(N-1)) ? '0 : pos + 1'b1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_err <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_data <= err ? in_data : mapped;
      out_err <= err;
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_rotor_unit.sv
// tb_rotor_unit: randomized and directed checks of rotor_unit against a cycle-level arithmetic model
module tb_rotor_unit;
  localparam int N = 26;
  localparam int W = 5;
  localparam int NOTCH = 4;
  logic clk, rst_n, cfg_we, pos_load, step_in, in_valid, in_ready, in_dir;
  logic out_valid, out_ready, out_err, carry_out;
  logic [W-1:0] cfg_addr, cfg_data, pos_val, ring_val, in_data, out_data, pos_out;
  rotor_unit #(.N(N), .W(W), .NOTCH(NOTCH)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .pos_load(pos_load), .pos_val(pos_val), .ring_val(ring_val), .step_in(step_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dir(in_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .carry_out(carry_out), .pos_out(pos_out)
  );
  always #5 clk = ~clk;
  int total, bad;
  int fwd_m[N], rev_m[N];
  int pos_m, ring_m, md;
  bit mv, me, mc, last_acc, collect;
  string rot_ii = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
  logic [W-1:0] got_q[$];
  always @(posedge clk) if (collect && out_valid && out_ready) got_q.push_back(out_data);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      fwd_m[k] = k;
      rev_m[k] = k;
    end
    pos_m = 0; ring_m = 0; mv = 0; md = 0; me = 0; mc = 0;
  endtask
  task automatic step();
    int e, t;
    bit rdy;
    @(negedge clk);
    rdy = (!mv || out_ready) && !cfg_we && !pos_load;
    check("in_ready", in_ready, rdy);
    check("out_valid", out_valid, mv);
    if (mv) begin
      check("out_data", out_data, md);
      check("out_err", out_err, me);
    end
    check("carry_out", carry_out, mc);
    check("pos_out", pos_out, pos_m);
    last_acc = in_valid && rdy;
    e = ((pos_m - ring_m) % N + N) % N;
    if (last_acc) begin
      mv = 1;
      me = in_data >= N;
      if (me) md = in_data;
      else begin
        t = in_dir ? rev_m[(in_data + e) % N] : fwd_m[(in_data + e) % N];
        md = ((t - e) % N + N) % N;
      end
    end else if (out_ready) mv = 0;
    mc = step_in && !pos_load && pos_m == NOTCH;
    if (pos_load) begin
      pos_m = pos_val % N;
      ring_m = ring_val % N;
    end else if (step_in) pos_m = (pos_m + 1) % N;
    if (cfg_we && cfg_addr < N && cfg_data < N) begin
      fwd_m[cfg_addr] = cfg_data;
      rev_m[cfg_data] = cfg_addr;
    end
    @(posedge clk); #1;
  endtask
  task automatic put(input int d, input bit dir);
    in_valid = 1; in_data = W'(d); in_dir = dir;
    step();
    in_valid = 0;
  endtask
  task automatic load(input int p, input int r);
    pos_load = 1; pos_val = W'(p); ring_val = W'(r);
    step();
    pos_load = 0;
  endtask
  task automatic cfg(input int a, input int d);
    cfg_we = 1; cfg_addr = W'(a); cfg_data = W'(d);
    step();
    cfg_we = 0;
  endtask
  initial begin
    int sent;
    total = 0; bad = 0; collect = 0;
    clk = 0; rst_n = 0; cfg_we = 0; cfg_addr = '0; cfg_data = '0; pos_load = 0;
    pos_val = '0; ring_val = '0; step_in = 0; in_valid = 0; in_data = '0; in_dir = 0;
    out_ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    check("rst_carry", carry_out, 0);
    check("rst_pos", pos_out, 0);
    rst_n = 1;
    @(posedge clk); #1;
    put(3, 0);
    check("rst_identity", out_data, 3);
    for (int i = 0; i < N; i++) cfg(i, int'(rot_ii[i]) - 65);
    load(0, 0);
    put(1, 0);
    check("r038_fwd", out_data, 9);
    check("r038_valid", out_valid, 1);
    put(9, 1);
    check("r038_rev", out_data, 1);
    load(1, 0);
    put(0, 0);
    check("r039_fwd", out_data, 8);
    put(8, 1);
    check("r039_rev", out_data, 0);
    load(4, 0);
    step_in = 1;
    step();
    step_in = 0;
    check("r040_pos", pos_out, 5);
    check("r040_carry", carry_out, 1);
    step();
    check("r040_carry_pulse", carry_out, 0);
    load(25, 0);
    step_in = 1;
    step();
    step_in = 0;
    check("r040_wrap_pos", pos_out, 0);
    check("r040_wrap_carry", carry_out, 0);
    load(0, 0);
    got_q.delete();
    collect = 1;
    sent = 0;
    for (int c = 0; c < 16; c++) begin
      in_valid = sent < 10;
      in_data = W'((sent * 3) % N);
      in_dir = 0;
      out_ready = !(c >= 3 && c <= 5);
      step();
      if (last_acc) sent++;
    end
    in_valid = 0; out_ready = 1;
    step(); step();
    collect = 0;
    check("r041_count", got_q.size(), 10);
    for (int i = 0; i < 10 && i < got_q.size(); i++) check("r041_order", got_q[i], fwd_m[(i * 3) % N]);
    put(27, 0);
    check("r042_data", out_data, 27);
    check("r042_err", out_err, 1);
    cfg(30, 3);
    cfg(3, 30);
    put(3, 0);
    check("r042_fwd_kept", out_data, 10);
    put(3, 1);
    check("r042_rev_kept", out_data, 2);
    for (int c = 0; c < 400; c++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_data = ($urandom_range(0, 7) == 0) ? W'($urandom_range(N, 31)) : W'($urandom_range(0, N - 1));
      in_dir = 1'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      step_in = $urandom_range(0, 4) == 0;
      pos_load = $urandom_range(0, 19) == 0;
      pos_val = W'($urandom_range(0, 31));
      ring_val = W'($urandom_range(0, 31));
      cfg_we = $urandom_range(0, 29) == 0;
      cfg_addr = W'($urandom_range(0, 31));
      cfg_data = W'($urandom_range(0, 31));
      step();
    end
    in_valid = 0; step_in = 0; pos_load = 0; cfg_we = 0; out_ready = 1;
    step();
    out_ready = 0;
    put(5, 0);
    check("r043_stalled", out_valid, 1);
    #2;
    rst_n = 0;
    #1;
    check("r043_valid_drop", out_valid, 0);
    check("r043_data_clr", out_data, 0);
    check("r043_pos_clr", pos_out, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    out_ready = 1;
    step();
    check("r043_no_ghost", out_valid, 0);
    put(0, 0);
    check("r043_ident_a", out_data, 0);
    check("r043_ident_valid", out_valid, 1);
    put(1, 0);
    check("r043_ident_b", out_data, 1);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
